video_out_stage: RTL

//  Parametrised pixel output stage between a core's packed LCD-style video (data, hsync, vsync, DEN)
//  and vga2dvid. Supersedes the fixed RGB332->3-bit register stage in the board tops.
//  - expands packed RGB of any split to C_depth bits per channel by bit replication
//  - normalises sync polarity and delays data, syncs and blank by a configurable pipeline depth
//  - provides aligned line/pixel counters and a frame-start pulse

---
 rtl/video_out_stage.sv | 136 +++++++++++++
 1 files changed

// File: rtl/video_out_stage.sv
// Pixel output stage: expands packed RGB, normalises sync polarity, tags line/pixel counters
// and delays everything by C_pipe cycles. Optional scanline dimming with VIDEO_OUT_SCANLINE_EN.
module video_out_stage #(
  parameter int unsigned C_r_bits    = 3,
  parameter int unsigned C_g_bits    = 3,
  parameter int unsigned C_b_bits    = 2,
  parameter int unsigned C_depth     = 8,
  parameter int unsigned C_pipe      = 2,
  parameter int unsigned C_hsync_inv = 0,
  parameter int unsigned C_vsync_inv = 0
) (
  input  logic                                   clk_pixel,
  input  logic                                   reset_n,
  input  logic [C_r_bits+C_g_bits+C_b_bits-1:0]  in_dat,
  input  logic                                   in_hsync,
  input  logic                                   in_vsync,
  input  logic                                   in_den,
`ifdef VIDEO_OUT_SCANLINE_EN
  input  logic                                   scanline_en,
`endif
  output logic [C_depth-1:0]                     out_red,
  output logic [C_depth-1:0]                     out_green,
  output logic [C_depth-1:0]                     out_blue,
  output logic                                   out_hsync,
  output logic                                   out_vsync,
  output logic                                   out_blank,
  output logic [10:0]                            out_line,
  output logic [11:0]                            out_pix,
  output logic                                   out_frame
);

  localparam int unsigned GOff = C_b_bits;
  localparam int unsigned ROff = C_g_bits + C_b_bits;

  typedef struct packed {
    logic [C_depth-1:0] r;
    logic [C_depth-1:0] g;
    logic [C_depth-1:0] b;
    logic               hsync;
    logic               vsync;
    logic               blank;
    logic               frame;
    logic [10:0]        line;
    logic [11:0]        pix;
  } sample_t;

  localparam sample_t IdleSample = '{r: '0, g: '0, b: '0, hsync: 1'b0, vsync: 1'b0,
                                     blank: 1'b1, frame: 1'b0, line: '0, pix: '0};

  sample_t     st_q    [C_pipe];
  sample_t     stage_d [C_pipe];
  sample_t     st_in;
  logic        s_h, s_v, h_rise, v_rise, frame_t;
  logic [10:0] line_q, line_t;
  logic [11:0] pix_q, pix_t, pix_d;
  logic [C_depth-1:0] exp_r, exp_g, exp_b;

  assign s_h    = in_hsync ^ C_hsync_inv[0];
  assign s_v    = in_vsync ^ C_vsync_inv[0];
  // Stage 0 holds the previous sample, so its syncs serve as the edge-detect history.
  assign h_rise = s_h & ~st_q[0].hsync;
  assign v_rise = s_v & ~st_q[0].vsync;

  // Bit replication, MSB first; a field at least C_depth wide yields its top bits.
  always_comb begin
    exp_r = '0;
    exp_g = '0;
    exp_b = '0;
    if (in_den) begin
      for (int j = 0; j < C_depth; j++) begin
        exp_r[C_depth-1-j] = in_dat[ROff + C_r_bits - 1 - (j % C_r_bits)];
        exp_g[C_depth-1-j] = in_dat[GOff + C_g_bits - 1 - (j % C_g_bits)];
        exp_b[C_depth-1-j] = in_dat[C_b_bits - 1 - (j % C_b_bits)];
      end
    end
  end

  always_comb begin
    line_t  = line_q;
    pix_t   = pix_q;
    frame_t = 1'b0;
    if (v_rise) begin
      line_t  = '0;
      pix_t   = '0;
      frame_t = 1'b1;
    end else if (h_rise) begin
      line_t = (line_q == 11'h7ff) ? line_q : line_q + 11'd1;
      pix_t  = '0;
    end
    // The pixel is tagged with pix_t; the count advances afterwards.
    pix_d = (in_den && pix_t != 12'hfff) ? pix_t + 12'd1 : pix_t;
  end

  always_comb begin
    st_in = '{r: exp_r, g: exp_g, b: exp_b, hsync: s_h, vsync: s_v, blank: ~in_den,
              frame: frame_t, line: line_t, pix: pix_t};
    stage_d[0] = st_in;
    for (int i = 1; i < C_pipe; i++) begin
      stage_d[i] = st_q[i-1];
    end
`ifdef VIDEO_OUT_SCANLINE_EN
    if (scanline_en && stage_d[C_pipe-1].line[0]) begin
      stage_d[C_pipe-1].r = stage_d[C_pipe-1].r >> 1;
      stage_d[C_pipe-1].g = stage_d[C_pipe-1].g >> 1;
      stage_d[C_pipe-1].b = stage_d[C_pipe-1].b >> 1;
    end
`endif
  end

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      for (int i = 0; i < C_pipe; i++) begin
        st_q[i] <= IdleSample;
      end
      line_q <= '0;
      pix_q  <= '0;
    end else begin
      for (int i = 0; i < C_pipe; i++) begin
        st_q[i] <= stage_d[i];
      end
      line_q <= line_t;
      pix_q  <= pix_d;
    end
  end

  assign out_red   = st_q[C_pipe-1].r;
  assign out_green = st_q[C_pipe-1].g;
  assign out_blue  = st_q[C_pipe-1].b;
  assign out_hsync = st_q[C_pipe-1].hsync;
  assign out_vsync = st_q[C_pipe-1].vsync;
  assign out_blank = st_q[C_pipe-1].blank;
  assign out_frame = st_q[C_pipe-1].frame;
  assign out_line  = st_q[C_pipe-1].line;
  assign out_pix   = st_q[C_pipe-1].pix;

endmodule
